// File: rtl/y86_regfile_sb.sv
// Y86 decode-stage register file with source/destination selection, two
// write-back ports (M over E), per-register pending counters and optional bypass.
module y86_regfile_sb #(
  parameter int               WIDTH      = 64,
  parameter int               PEND_W     = 2,
  parameter bit               BYPASS     = 1'b1,
  parameter logic [WIDTH-1:0] STACK_INIT = '0
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             d_valid,
  input  logic [3:0]       icode,
  input  logic [3:0]       rA,
  input  logic [3:0]       rB,
  output logic             d_stall,
  output logic [3:0]       srcA,
  output logic [3:0]       srcB,
  output logic [3:0]       dstE,
  output logic [3:0]       dstM,
  output logic [WIDTH-1:0] valA,
  output logic [WIDTH-1:0] valB,
  input  logic             w_valid,
  input  logic [3:0]       w_dstE,
  input  logic [WIDTH-1:0] w_valE,
  input  logic             w_cnd,
  input  logic [3:0]       w_dstM,
  input  logic [WIDTH-1:0] w_valM,
  input  logic [3:0]       dbg_sel,
  output logic [WIDTH-1:0] dbg_val
);

  localparam logic [3:0] NONE    = 4'hF;
  localparam int         CNT_MAX = (1 << PEND_W) - 1;

  logic [WIDTH-1:0]  regs  [15];
  logic [PEND_W-1:0] cnt   [15];
  // Views with a hard-wired zero slot for id F, so reads never need a guard.
  logic [WIDTH-1:0]  reg_v [16];
  logic [PEND_W-1:0] cnt_v [16];

  int   inc     [15];
  int   dec     [15];
  int   cnt_nxt [15];

  logic wr_e, wr_m;
  logic hit_a_e, hit_a_m, hit_b_e, hit_b_m;
  logic cov_a, cov_b, haz_a, haz_b;
  logic full, issue;

  always_comb begin
    srcA = NONE;
    srcB = NONE;
    dstE = NONE;
    dstM = NONE;
    case (icode)
      4'h2: begin srcA = rA;   dstE = rB; end
      4'h3: begin dstE = rB; end
      4'h4: begin srcA = rA;   srcB = rB; end
      4'h5: begin srcB = rB;   dstM = rA; end
      4'h6: begin srcA = rA;   srcB = rB;   dstE = rB; end
      4'h8: begin srcB = 4'h4; dstE = 4'h4; end
      4'h9: begin srcA = 4'h4; srcB = 4'h4; dstE = 4'h4; end
      4'hA: begin srcA = rA;   srcB = 4'h4; dstE = 4'h4; end
      4'hB: begin srcA = 4'h4; srcB = 4'h4; dstE = 4'h4; dstM = rA; end
      default: ;
    endcase
  end

  always_comb begin
    for (int r = 0; r < 15; r++) begin
      reg_v[r] = regs[r];
      cnt_v[r] = cnt[r];
    end
    reg_v[15] = '0;
    cnt_v[15] = '0;
  end

  assign wr_e = w_valid & w_cnd & (w_dstE != NONE);
  assign wr_m = w_valid & (w_dstM != NONE);

  assign hit_a_e = wr_e & (w_dstE == srcA);
  assign hit_a_m = wr_m & (w_dstM == srcA);
  assign hit_b_e = wr_e & (w_dstE == srcB);
  assign hit_b_m = wr_m & (w_dstM == srcB);

  // Only the last outstanding writer may be forwarded; with more in flight the
  // register would still be stale after this write lands.
  assign cov_a = BYPASS & (cnt_v[srcA] == PEND_W'(1)) & (hit_a_e | hit_a_m);
  assign cov_b = BYPASS & (cnt_v[srcB] == PEND_W'(1)) & (hit_b_e | hit_b_m);
  assign haz_a = (cnt_v[srcA] != '0) & ~cov_a;
  assign haz_b = (cnt_v[srcB] != '0) & ~cov_b;

  assign valA    = cov_a ? (hit_a_m ? w_valM : w_valE) : reg_v[srcA];
  assign valB    = cov_b ? (hit_b_m ? w_valM : w_valE) : reg_v[srcB];
  assign dbg_val = reg_v[dbg_sel];

  // Saturation is judged on the increments this decode would apply, so it does
  // not depend on the issue decision it feeds.
  always_comb begin
    full = 1'b0;
    for (int r = 0; r < 15; r++) begin
      inc[r] = int'(dstE == 4'(r)) + int'(dstM == 4'(r));
      dec[r] = w_valid ? int'(w_dstE == 4'(r)) + int'(w_dstM == 4'(r)) : 0;
      if (inc[r] != 0 && int'(cnt[r]) + inc[r] - dec[r] > CNT_MAX) full = 1'b1;
    end
  end

  assign d_stall = d_valid & (haz_a | haz_b | full);
  assign issue   = d_valid & ~d_stall;

  always_comb begin
    for (int r = 0; r < 15; r++) begin
      cnt_nxt[r] = int'(cnt[r]) - dec[r] + (issue ? inc[r] : 0);
      if (cnt_nxt[r] < 0) cnt_nxt[r] = 0;
    end
  end

  // NOTE: the register array is reset because its reset contents (including
  // %rsp) are architecturally visible, unlike a plain data RAM.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int r = 0; r < 15; r++) begin
        regs[r] <= (r == 4) ? STACK_INIT : '0;
        cnt[r]  <= '0;
      end
    end else begin
      // NOTE: non-blocking assignments keep every register sampling pre-edge values.
      for (int r = 0; r < 15; r++) begin
        cnt[r] <= PEND_W'(cnt_nxt[r]);
        if (wr_m && w_dstM == 4'(r))      regs[r] <= w_valM;
        else if (wr_e && w_dstE == 4'(r)) regs[r] <= w_valE;
      end
    end
  end

endmodule

// File: tb/tb_y86_regfile_sb.sv
// Bench for y86_regfile_sb: two instances (BYPASS=0 and BYPASS=1) share stimulus
// and are checked every cycle against a register/pending-count model.
module tb_y86_regfile_sb;

  localparam logic [3:0] NO   = 4'hF;
  localparam int         MAXC = 3;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic        d_valid, w_valid, w_cnd;
  logic [3:0]  icode, rA, rB, w_dstE, w_dstM, dbg_sel;
  logic [63:0] w_valE, w_valM;

  logic [1:0]       d_stall_o;
  logic [1:0][3:0]  srcA_o, srcB_o, dstE_o, dstM_o;
  logic [1:0][63:0] valA_o, valB_o, dbg_o;

  int n_checks = 0;
  int n_pass   = 0;

  int          m_cnt [2][16];
  logic [63:0] m_reg [2][16];

  always #5 clk = ~clk;

  y86_regfile_sb #(.WIDTH(64), .PEND_W(2), .BYPASS(1'b0), .STACK_INIT(64'h200)) dut0 (
    .clk(clk), .rst_n(rst_n), .d_valid(d_valid), .icode(icode), .rA(rA), .rB(rB),
    .d_stall(d_stall_o[0]), .srcA(srcA_o[0]), .srcB(srcB_o[0]), .dstE(dstE_o[0]),
    .dstM(dstM_o[0]), .valA(valA_o[0]), .valB(valB_o[0]), .w_valid(w_valid),
    .w_dstE(w_dstE), .w_valE(w_valE), .w_cnd(w_cnd), .w_dstM(w_dstM), .w_valM(w_valM),
    .dbg_sel(dbg_sel), .dbg_val(dbg_o[0]));

  y86_regfile_sb #(.WIDTH(64), .PEND_W(2), .BYPASS(1'b1), .STACK_INIT(64'h200)) dut1 (
    .clk(clk), .rst_n(rst_n), .d_valid(d_valid), .icode(icode), .rA(rA), .rB(rB),
    .d_stall(d_stall_o[1]), .srcA(srcA_o[1]), .srcB(srcB_o[1]), .dstE(dstE_o[1]),
    .dstM(dstM_o[1]), .valA(valA_o[1]), .valB(valB_o[1]), .w_valid(w_valid),
    .w_dstE(w_dstE), .w_valE(w_valE), .w_cnd(w_cnd), .w_dstM(w_dstM), .w_valM(w_valM),
    .dbg_sel(dbg_sel), .dbg_val(dbg_o[1]));

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_checks++;
    if (act === exp) n_pass++;
    else $display("FAIL %s: got %0h, expected %0h", name, act, exp);
  endtask

  // ---------------- model ----------------
  function automatic logic [15:0] msel(input logic [3:0] ic, input logic [3:0] ra, input logic [3:0] rb);
    logic [3:0] sa, sb, de, dm;
    sa = NO; sb = NO; de = NO; dm = NO;
    if (ic inside {4'h2, 4'h4, 4'h6, 4'hA}) sa = ra;
    else if (ic inside {4'h9, 4'hB}) sa = 4'h4;
    if (ic inside {4'h4, 4'h5, 4'h6}) sb = rb;
    else if (ic inside {4'h8, 4'h9, 4'hA, 4'hB}) sb = 4'h4;
    if (ic inside {4'h2, 4'h3, 4'h6}) de = rb;
    else if (ic inside {4'h8, 4'h9, 4'hA, 4'hB}) de = 4'h4;
    if (ic inside {4'h5, 4'hB}) dm = ra;
    return {sa, sb, de, dm};
  endfunction

  function automatic int mcnt(input int b, input logic [3:0] id);
    return (id == NO) ? 0 : m_cnt[b][id];
  endfunction

  function automatic bit mwrites(input logic [3:0] id);
    return id != NO && w_valid && (w_dstM == id || (w_cnd && w_dstE == id));
  endfunction

  function automatic logic [63:0] mwdata(input logic [3:0] id);
    return (w_valid && w_dstM == id) ? w_valM : w_valE;
  endfunction

  function automatic bit mcov(input int b, input logic [3:0] id);
    return b == 1 && mcnt(b, id) == 1 && mwrites(id);
  endfunction

  function automatic bit mhaz(input int b, input logic [3:0] id);
    return mcnt(b, id) != 0 && !mcov(b, id);
  endfunction

  function automatic int mafter(input int b, input logic [3:0] id, input logic [3:0] de, input logic [3:0] dm);
    int n;
    n = mcnt(b, id) + int'(id == de) + int'(id == dm);
    if (w_valid) n = n - int'(w_dstE == id) - int'(w_dstM == id);
    return n;
  endfunction

  function automatic bit mstall(input int b);
    logic [15:0] s;
    bit full;
    s = msel(icode, rA, rB);
    full = (s[7:4] != NO && mafter(b, s[7:4], s[7:4], s[3:0]) > MAXC) ||
           (s[3:0] != NO && mafter(b, s[3:0], s[7:4], s[3:0]) > MAXC);
    return d_valid && (mhaz(b, s[15:12]) || mhaz(b, s[11:8]) || full);
  endfunction

  function automatic logic [63:0] mval(input int b, input logic [3:0] id);
    if (id == NO) return 64'h0;
    return mcov(b, id) ? mwdata(id) : m_reg[b][id];
  endfunction

  initial begin
    forever begin
      @(posedge clk or negedge rst_n);
      if (!rst_n) begin
        for (int b = 0; b < 2; b++)
          for (int r = 0; r < 16; r++) begin
            m_cnt[b][r] = 0;
            m_reg[b][r] = (r == 4) ? 64'h200 : 64'h0;
          end
      end else begin
        for (int b = 0; b < 2; b++) begin
          logic [15:0] s;
          bit iss;
          s = msel(icode, rA, rB);
          iss = d_valid && !mstall(b);
          for (int r = 0; r < 15; r++) begin
            int c;
            c = m_cnt[b][r];
            if (iss) c = c + int'(s[7:4] == 4'(r)) + int'(s[3:0] == 4'(r));
            if (w_valid) c = c - int'(w_dstE == 4'(r)) - int'(w_dstM == 4'(r));
            m_cnt[b][r] = (c < 0) ? 0 : c;
          end
          if (w_valid) begin
            if (w_cnd && w_dstE != NO) m_reg[b][w_dstE] = w_valE;
            if (w_dstM != NO) m_reg[b][w_dstM] = w_valM;
          end
        end
      end
    end
  end

  // Every-cycle comparison of both instances against the model.
  initial begin
    forever begin
      @(negedge clk);
      for (int b = 0; b < 2; b++) begin
        logic [15:0] s;
        s = msel(icode, rA, rB);
        check($sformatf("b%0d d_stall", b), 64'(d_stall_o[b]), 64'(mstall(b)));
        check($sformatf("b%0d srcA", b), 64'(srcA_o[b]), 64'(s[15:12]));
        check($sformatf("b%0d srcB", b), 64'(srcB_o[b]), 64'(s[11:8]));
        check($sformatf("b%0d dstE", b), 64'(dstE_o[b]), 64'(s[7:4]));
        check($sformatf("b%0d dstM", b), 64'(dstM_o[b]), 64'(s[3:0]));
        check($sformatf("b%0d valA", b), valA_o[b], mval(b, s[15:12]));
        check($sformatf("b%0d valB", b), valB_o[b], mval(b, s[11:8]));
        check($sformatf("b%0d dbg_val", b), dbg_o[b], (dbg_sel == NO) ? 64'h0 : m_reg[b][dbg_sel]);
      end
    end
  end

  // ---------------- stimulus ----------------
  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic no_wb();
    w_valid = 1'b0; w_dstE = NO; w_dstM = NO; w_valE = '0; w_valM = '0; w_cnd = 1'b1;
  endtask

  task automatic idle();
    d_valid = 1'b0; icode = 4'h1; rA = NO; rB = NO;
    no_wb();
  endtask

  task automatic decode(input logic [3:0] ic, input logic [3:0] a, input logic [3:0] b);
    d_valid = 1'b1; icode = ic; rA = a; rB = b;
  endtask

  task automatic wb(input logic [3:0] de, input logic [63:0] ve, input logic [3:0] dm,
                    input logic [63:0] vm, input logic c);
    w_valid = 1'b1; w_dstE = de; w_valE = ve; w_dstM = dm; w_valM = vm; w_cnd = c;
  endtask

  task automatic lit_both(input string name, input logic [63:0] a0, input logic [63:0] a1,
                          input logic [63:0] exp);
    check({name, " b0 lit"}, a0, exp);
    check({name, " b1 lit"}, a1, exp);
  endtask

  initial begin
    idle();
    dbg_sel = 4'h0;
    tick(); tick();
    rst_n = 1'b1;

    // Reset contents and empty scoreboard.
    for (int r = 0; r < 15; r++) begin
      dbg_sel = 4'(r);
      @(negedge clk);
      lit_both("reset dbg", dbg_o[0], dbg_o[1], (r == 4) ? 64'h200 : 64'h0);
      tick();
    end
    for (int r = 0; r < 15; r++) begin
      decode(4'h4, 4'(r), 4'(14 - r));
      @(negedge clk);
      lit_both("reset no stall", 64'(d_stall_o[0]), 64'(d_stall_o[1]), 64'h0);
      tick();
    end
    idle();

    // Both ports to r4: M wins.
    wb(4'h4, 64'h100, 4'h4, 64'h55, 1'b1);
    tick();
    idle(); dbg_sel = 4'h4;
    @(negedge clk);
    lit_both("port priority", dbg_o[0], dbg_o[1], 64'h55);
    tick();

    // RAW hazard: irmovq -> r2, then addq r2,r5.
    decode(4'h3, NO, 4'h2);
    @(negedge clk);
    lit_both("irmovq issue", 64'(d_stall_o[0]), 64'(d_stall_o[1]), 64'h0);
    tick();
    decode(4'h6, 4'h2, 4'h5);
    @(negedge clk);
    lit_both("raw stall", 64'(d_stall_o[0]), 64'(d_stall_o[1]), 64'h1);
    tick(); tick();
    wb(4'h2, 64'h2A, NO, 64'h0, 1'b1);
    @(negedge clk);
    check("raw wcycle b1 stall", 64'(d_stall_o[1]), 64'h0);
    check("raw wcycle b1 valA", valA_o[1], 64'h2A);
    check("raw wcycle b0 stall", 64'(d_stall_o[0]), 64'h1);
    tick();
    no_wb();
    @(negedge clk);
    check("raw next b0 stall", 64'(d_stall_o[0]), 64'h0);
    check("raw next b0 valA", valA_o[0], 64'h2A);
    tick();
    idle();
    wb(4'h5, 64'h5, NO, 64'h0, 1'b1);
    tick();
    idle();

    // Failed cmov: retire decrements but does not write or forward.
    decode(4'h2, 4'h1, 4'h3);
    tick();
    decode(4'h6, 4'h3, 4'h6);
    wb(4'h3, 64'h7, NO, 64'h0, 1'b0);
    @(negedge clk);
    lit_both("cmov retire stall", 64'(d_stall_o[0]), 64'(d_stall_o[1]), 64'h1);
    tick();
    no_wb();
    @(negedge clk);
    lit_both("cmov after stall", 64'(d_stall_o[0]), 64'(d_stall_o[1]), 64'h0);
    lit_both("cmov after valA", valA_o[0], valA_o[1], 64'h0);
    tick();
    idle(); dbg_sel = 4'h3;
    wb(4'h6, 64'h1, NO, 64'h0, 1'b1);
    @(negedge clk);
    lit_both("cmov reg3", dbg_o[0], dbg_o[1], 64'h0);
    tick();
    idle();

    // popq %rsp reserves r4 twice.
    decode(4'hB, 4'h4, NO);
    @(negedge clk);
    lit_both("popq stall", 64'(d_stall_o[0]), 64'(d_stall_o[1]), 64'h0);
    lit_both("popq dstM", 64'(dstM_o[0]), 64'(dstM_o[1]), 64'h4);
    tick();
    @(negedge clk);
    lit_both("popq2 stall", 64'(d_stall_o[0]), 64'(d_stall_o[1]), 64'h1);
    tick();
    wb(4'h4, 64'h10, 4'h4, 64'h20, 1'b1);
    @(negedge clk);
    lit_both("popq2 cnt2 stall", 64'(d_stall_o[0]), 64'(d_stall_o[1]), 64'h1);
    tick();
    no_wb();
    @(negedge clk);
    lit_both("popq2 go valA", valA_o[0], valA_o[1], 64'h20);
    tick();
    idle();
    wb(4'h4, 64'h30, 4'h4, 64'h40, 1'b1);
    tick();
    idle();

    // Saturation at three in-flight writers to r3.
    for (int i = 0; i < 3; i++) begin
      decode(4'h3, NO, 4'h3);
      @(negedge clk);
      lit_both("sat fill", 64'(d_stall_o[0]), 64'(d_stall_o[1]), 64'h0);
      tick();
    end
    decode(4'h3, NO, 4'h3);
    @(negedge clk);
    lit_both("sat full", 64'(d_stall_o[0]), 64'(d_stall_o[1]), 64'h1);
    tick();
    wb(4'h3, 64'h9, NO, 64'h0, 1'b1);
    @(negedge clk);
    lit_both("sat release", 64'(d_stall_o[0]), 64'(d_stall_o[1]), 64'h0);
    tick();
    idle();
    for (int i = 0; i < 3; i++) begin
      wb(4'h3, 64'h9, NO, 64'h0, 1'b1);
      tick();
    end
    idle();

    // Reset in the middle of a pending write to r2.
    decode(4'h3, NO, 4'h2);
    tick();
    idle(); dbg_sel = 4'h2;
    rst_n = 1'b0;
    @(negedge clk);
    lit_both("midrst reg2", dbg_o[0], dbg_o[1], 64'h0);
    tick();
    rst_n = 1'b1;
    decode(4'h6, 4'h2, 4'h5);
    @(negedge clk);
    lit_both("midrst stall", 64'(d_stall_o[0]), 64'(d_stall_o[1]), 64'h0);
    lit_both("midrst valA", valA_o[0], valA_o[1], 64'h0);
    tick();
    idle();
    wb(4'h2, 64'h33, 4'h5, 64'h44, 1'b1);
    tick();
    decode(4'h6, 4'h2, 4'h5);
    no_wb();
    @(negedge clk);
    lit_both("late retire stall", 64'(d_stall_o[0]), 64'(d_stall_o[1]), 64'h0);
    lit_both("late retire valA", valA_o[0], valA_o[1], 64'h33);
    tick();
    idle();
    @(negedge clk);
    #1;
    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule

// File: doc/y86_regfile_sb.md
# y86_regfile_sb

Parametrised decode-stage register file for the Y86 core, with an in-order scoreboard. It replaces the flat 15-output register array with the following:
- Y86 source/destination selection from icode/rA/rB.
- Two write-back ports (E and M) with M priority.
- Per-register pending counters that raise a decode stall on read-after-write hazards.
- Optional same-cycle write-to-read bypass.

It sits between fetch and execute, with write-back driven from the memory/write-back stage.

## Interface
- WIDTH, 64, data word width.
- PEND_W, 2, width of each per-register pending counter (max in-flight writers per register = 2^PEND_W-1).
- BYPASS, 1, 1 enables write-port-to-read-port forwarding in the write cycle; 0 disables it.
- STACK_INIT, 0, reset value of register 4 (%rsp); truncated to WIDTH.
- clk  in  1  clock, all state updates on rising edge.
- rst_n  in  1  asynchronous, active-low reset.
- d_valid  in  1  decode slot holds a valid instruction.
- icode  in  4  instruction code.
- rA  in  4  register field A (4'hF = none).
- rB  in  4  register field B.
- d_stall  out  1  decode must hold; instruction not issued this cycle.
- srcA  out  4  selected source A id.
- srcB  out  4  selected source B id.
- dstE  out  4  selected E destination id.
- dstM  out  4  selected M destination id.
- valA  out  WIDTH  read data for srcA (0 when srcA=F).
- valB  out  WIDTH  read data for srcB (0 when srcB=F).
- w_valid  in  1  write-back slot valid.
- w_dstE  in  4  E write destination.
- w_valE  in  WIDTH  E write data.
- w_cnd  in  1  0 suppresses the E data write (failed cmov); tie 1 otherwise.
- w_dstM  in  4  M write destination.
- w_valM  in  WIDTH  M write data.
- dbg_sel  in  4  debug read select.
- dbg_val  out  WIDTH  register[dbg_sel], 0 for F; no bypass.

## Operation
**Register storage**
- 15 registers, ids 0..14; id 4'hF means none and is never stored or counted.

**Source/destination selection (combinational, icode hex)**
- srcA = rA for 2,4,6,A; 4 for 9,B; else F.
- srcB = rB for 4,5,6; 4 for 8,9,A,B; else F.
- dstE = rB for 2,3,6; 4 for 8,9,A,B; else F.
- dstM = rA for 5,B; else F.
- All four selectors are driven regardless of d_valid.

**Write-back (when w_valid=1)**
- Write w_valE to w_dstE if w_cnd=1 and w_dstE≠F.
- Write w_valM to w_dstM if w_dstM≠F.
- If both ports target the same id, M wins.

**Scoreboard**
- Per-register counter cnt[r], PEND_W bits.
- Issue = d_valid & ~d_stall.
- On issue: +1 to cnt[dstE] and +1 to cnt[dstM]; +2 when they are equal (popq %rsp).
- On w_valid: −1 for w_dstE (independent of w_cnd, since the slot was reserved) and −1 for w_dstM.
- Issue and retire on the same register in one cycle apply their net change.
- Decrementing a zero counter is a protocol error; the counter holds at 0.

**Stall rule (d_stall=1 iff d_valid and any of the following)**
- srcA≠F and cnt[srcA]≠0, unless the write is covered.
- srcB≠F and cnt[srcB]≠0, unless the write is covered.
- cnt[dstE] or cnt[dstM] would exceed 2^PEND_W−1 after this issue's increments, counting same-cycle decrements.

A source write is "covered" only when all of the following hold:
- BYPASS=1.
- cnt[src]=1.
- The src is written this cycle by a port that actually writes it (E only if w_cnd=1).

A failed-cmov E retire (w_cnd=0) decrements but is not covered. Decode stalls one more cycle, then reads the unchanged register.

**Read data**
- valA/valB return the register contents.
- When covered, they instead return the bypassed write data, with M priority if both ports match.

## Timing
**Reset (async assert, sync-safe release)**
- All registers are 0 except reg 4 = STACK_INIT.
- All cnt = 0.
- Outputs follow their combinational definitions with that state: d_stall=0, valA/valB/dbg_val reflect the reset contents.
- Assertion mid-operation discards all pending reservations immediately; in-flight write-backs after release still decrement but clamp at 0.

**Latency**
- Register writes and counter updates take effect at the rising edge.
- Reads and d_stall are combinational, with zero latency.

**Read-after-write**
- BYPASS=0: decode stalls through the write cycle and reads the new value the cycle after.
- BYPASS=1: decode issues in the write cycle itself with forwarded data.

**Issue/retire concurrency**
- An instruction issuing in the cycle its own source retires sees the retire-adjusted count.

## Test plan
- **Reset.** STACK_INIT=64'h200, rst_n low then high. Expect dbg_sel=4 → 64'h200, dbg_sel=0..14 others → 0, d_stall=0, all cnt 0.
- **Port priority.** w_valid=1, w_dstE=4, w_valE=64'h100, w_dstM=4, w_valM=64'h55. Expect reg4=64'h55 next cycle.
- **Failed cmov.** Issue icode 2 rA=1 rB=3, then retire w_dstE=3 w_valE=64'h7 w_cnd=0. Expect reg3 unchanged, cnt[3] back to 0, and a following addq reading r3 stalls exactly one extra cycle.
- **RAW hazard.** Issue irmovq rB=2, then decode addq rA=2 rB=5. Expect d_stall=1 until the retire cycle with w_dstE=2, w_valE=64'h2A. With BYPASS=1, d_stall drops that cycle with valA=64'h2A; with BYPASS=0, it drops one cycle later with valA=64'h2A.
- **Saturation.** PEND_W=2. Issue three irmovq to r3 without retire; the fourth is stalled. One retire in the same cycle releases it.
- **Mid-operation reset.** Assert rst_n with cnt[2]=1 pending. Expect cnt cleared, reg2=0, and the next decode reading r2 not stalled.
